// File: rtl/cache_flush_sequencer_pkg.sv
// rtl/cache_flush_sequencer_pkg.sv - shared types and constants for the cache flush sequencer
package cache_flush_sequencer_pkg;

   localparam int FLUSH_TIMEOUT_CYCLES      = 4096;
   localparam int FLUSH_COUNT_DEFAULT_WIDTH = 16;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_MEM_DRAIN = 3'd1,
      S_DC_REQ    = 3'd2,
      S_DC_WAIT   = 3'd3,
      S_IC_REQ    = 3'd4,
      S_IC_WAIT   = 3'd5,
      S_DONE      = 3'd6
   } flush_seq_state_e;

   typedef logic [FLUSH_COUNT_DEFAULT_WIDTH-1:0] flush_count_path_t;

   // Phases in which the sequencer is waiting on something outside itself.
   function automatic logic phase_timed(flush_seq_state_e s);
      return (s != S_IDLE) && (s != S_DONE);
   endfunction

endpackage

// File: rtl/cache_flush_sequencer_if.sv
// rtl/cache_flush_sequencer_if.sv - flush handshake bundle between core, memory controller and caches
interface cache_flush_sequencer_if #(
   parameter int FLUSH_COUNT_WIDTH = 16
);
   logic                         flushReq;
   logic                         flushReqAck;
   logic                         flushBusy;
   logic                         memAccessBusy;
   logic                         dcFlushReq;
   logic                         dcFlushReqAck;
   logic                         dcFlushComplete;
   logic                         icFlushReq;
   logic                         icFlushReqAck;
   logic                         icFlushComplete;
   logic                         flushComplete;
   logic                         flushTimeout;
   logic [FLUSH_COUNT_WIDTH-1:0] flushCount;

   modport master (
      input  flushReq, memAccessBusy,
      input  dcFlushReqAck, dcFlushComplete, icFlushReqAck, icFlushComplete,
      output flushReqAck, flushBusy, dcFlushReq, icFlushReq,
      output flushComplete, flushTimeout, flushCount
   );

   modport slave (
      output flushReq, memAccessBusy,
      output dcFlushReqAck, dcFlushComplete, icFlushReqAck, icFlushComplete,
      input  flushReqAck, flushBusy, dcFlushReq, icFlushReq,
      input  flushComplete, flushTimeout, flushCount
   );
endinterface

// File: rtl/cache_flush_sequencer_phase_timer.sv
// rtl/cache_flush_sequencer_phase_timer.sv - saturating per-phase cycle counter with expiry strobe
module cache_flush_sequencer_phase_timer #(
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expire
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CYCLES);

   logic [TW-1:0] count_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else if (clear) begin
         count_q <= '0;
      end else if (enable && (count_q != LIMIT)) begin
         count_q <= count_q + 1'b1;
      end
   end

   // Strobes on the cycle whose increment lands the count on LIMIT.
   assign expire = enable && !clear && (count_q == LIMIT - 1'b1);

endmodule

// File: rtl/cache_flush_sequencer.sv
// rtl/cache_flush_sequencer.sv - orders DCache writeback, ICache invalidate and the completion broadcast
module cache_flush_sequencer
   import cache_flush_sequencer_pkg::*;
#(
   parameter int TIMEOUT_CYCLES    = FLUSH_TIMEOUT_CYCLES,
   parameter int FLUSH_COUNT_WIDTH = FLUSH_COUNT_DEFAULT_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst,
   cache_flush_sequencer_if.master  bus
);
   flush_seq_state_e             state_q;
   flush_seq_state_e             state_d;
   logic                         dc_req_q;
   logic                         ic_req_q;
   logic                         busy_q;
   logic                         complete_q;
   logic                         timeout_q;
   logic [FLUSH_COUNT_WIDTH-1:0] count_q;
   logic                         accept;
   logic                         expire;

   // The ack must read low while rst is held even if the core keeps its request up.
   assign accept = !rst && (state_q == S_IDLE) && bus.flushReq;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:      if (bus.flushReq) state_d = S_MEM_DRAIN;
         S_MEM_DRAIN: if (!bus.memAccessBusy) state_d = S_DC_REQ;
         S_DC_REQ: begin
            if (bus.dcFlushReqAck && bus.dcFlushComplete) state_d = S_IC_REQ;
            else if (bus.dcFlushReqAck)                   state_d = S_DC_WAIT;
         end
         S_DC_WAIT:   if (bus.dcFlushComplete) state_d = S_IC_REQ;
         S_IC_REQ: begin
            if (bus.icFlushReqAck && bus.icFlushComplete) state_d = S_DONE;
            else if (bus.icFlushReqAck)                   state_d = S_IC_WAIT;
         end
         S_IC_WAIT:   if (bus.icFlushComplete) state_d = S_DONE;
         S_DONE:      state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase
   end

   cache_flush_sequencer_phase_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_phase_timer (
      .clk    (clk),
      .rst    (rst),
      .clear  (state_d != state_q),
      .enable (phase_timed(state_q)),
      .expire (expire)
   );

   // Outputs are decoded from the next state so they line up with the state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         dc_req_q   <= 1'b0;
         ic_req_q   <= 1'b0;
         busy_q     <= 1'b0;
         complete_q <= 1'b0;
         timeout_q  <= 1'b0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         dc_req_q   <= (state_d == S_DC_REQ);
         ic_req_q   <= (state_d == S_IC_REQ);
         busy_q     <= (state_d != S_IDLE);
         complete_q <= (state_d == S_DONE);
         if (state_q == S_DONE) begin
            count_q <= count_q + 1'b1;
         end
         if (accept) begin
            timeout_q <= 1'b0;
         end else if (expire) begin
            timeout_q <= 1'b1;
         end
      end
   end

   assign bus.flushReqAck   = accept;
   assign bus.flushBusy     = busy_q;
   assign bus.dcFlushReq    = dc_req_q;
   assign bus.icFlushReq    = ic_req_q;
   assign bus.flushComplete = complete_q;
   assign bus.flushTimeout  = timeout_q;
   assign bus.flushCount    = count_q;

endmodule

// File: tb/tb_cache_flush_sequencer.sv
// tb/tb_cache_flush_sequencer.sv - timeline-model bench for cache_flush_sequencer
module tb_cache_flush_sequencer;
   localparam int T     = 8;
   localparam int W     = 2;
   localparam int MAXC  = 4000;
   localparam int NDIR  = 9;
   localparam int NRAND = 30;

   typedef struct {
      int m; int da; int dcc; int ia; int icc; int early; int roff;
   } step_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   cache_flush_sequencer_if #(.FLUSH_COUNT_WIDTH(W)) bus ();

   cache_flush_sequencer #(
      .TIMEOUT_CYCLES    (T),
      .FLUSH_COUNT_WIDTH (W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   bit in_req [MAXC];
   bit in_mem [MAXC];
   bit in_dca [MAXC];
   bit in_dcc [MAXC];
   bit in_ica [MAXC];
   bit in_icc [MAXC];
   bit e_ack  [MAXC];
   bit e_busy [MAXC];
   bit e_dc   [MAXC];
   bit e_ic   [MAXC];
   bit e_cmp  [MAXC];
   bit to_set [MAXC];
   bit to_clr [MAXC];
   bit c_inc  [MAXC];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int prev_a    = -1;
   int prev_done = -1;
   int last_done = 0;
   step_t dir [NDIR];

   task automatic chk1(string tag, logic obs, logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cycle=%0d observed=%0b expected=%0b", tag, cyc, obs, exp);
      end
   endtask

   task automatic chkc(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
      end
   endtask

   // A phase of length L starting at s raises the flag at s+T once L exceeds T.
   task automatic mark_phase(int s, int len);
      if (len >= T + 1) to_set[s + T] = 1'b1;
   endtask

   // Lays one flush onto the absolute-cycle timeline using only the handshake rules.
   task automatic plan(step_t st);
      int r, a, dcs, adc, ics, aic, done;
      r = (st.roff < 0) ? prev_a + 1 : prev_done + st.roff;
      if (r < 1) r = 1;
      a = (r > prev_done + 1) ? r : prev_done + 1;
      for (int i = r; i <= a; i++) in_req[i] = 1'b1;
      e_ack[a] = 1'b1;
      for (int i = a + 1; i <= a + st.m; i++) in_mem[i] = 1'b1;
      dcs = a + st.m + 2;
      adc = dcs + st.da;
      in_dca[adc] = 1'b1;
      in_dcc[adc + st.dcc] = 1'b1;
      if (st.early != 0 && st.da >= 1) in_dcc[dcs] = 1'b1;
      for (int i = dcs; i <= adc; i++) e_dc[i] = 1'b1;
      ics = adc + st.dcc + 1;
      aic = ics + st.ia;
      in_ica[aic] = 1'b1;
      in_icc[aic + st.icc] = 1'b1;
      if (st.early != 0 && st.ia >= 1) in_icc[ics] = 1'b1;
      for (int i = ics; i <= aic; i++) e_ic[i] = 1'b1;
      done = aic + st.icc + 1;
      for (int i = a + 1; i <= done; i++) e_busy[i] = 1'b1;
      e_cmp[done]   = 1'b1;
      c_inc[done+1] = 1'b1;
      to_clr[a+1]   = 1'b1;
      mark_phase(a + 1, st.m + 1);
      mark_phase(dcs, st.da + 1);
      if (st.dcc > 0) mark_phase(adc + 1, st.dcc);
      mark_phase(ics, st.ia + 1);
      if (st.icc > 0) mark_phase(aic + 1, st.icc);
      prev_a    = a;
      prev_done = done;
      last_done = done;
   endtask

   function automatic int rnd_len(int lo_max, int hi_min, int hi_max);
      if ($urandom_range(0, 5) == 0) return int'($urandom_range(hi_min, hi_max));
      return int'($urandom_range(0, lo_max));
   endfunction

   initial begin
      logic          exp_to;
      logic [W-1:0]  exp_cnt;
      step_t         st;

      bus.flushReq = 1'b0;        bus.memAccessBusy = 1'b0;
      bus.dcFlushReqAck = 1'b0;   bus.dcFlushComplete = 1'b0;
      bus.icFlushReqAck = 1'b0;   bus.icFlushComplete = 1'b0;

      // m, da, dcc, ia, icc, early, roff
      dir[0] = '{0, 1, 1, 1, 1, 0, 2};   // basic
      dir[1] = '{10, 1, 1, 1, 1, 0, 2};  // memory drain, long enough to time out
      dir[2] = '{0, 2, 0, 2, 0, 1, 1};   // combined ack+complete, early completes ignored
      dir[3] = '{0, 0, 1, 1, 20, 0, 3};  // ICache stall
      dir[4] = '{0, 0, 0, 0, 0, 0, 0};   // request high during DONE
      dir[5] = '{0, 0, 0, 0, 0, 0, -1};  // back-to-back
      dir[6] = '{0, 1, 0, 0, 1, 0, -1};
      dir[7] = '{1, 0, 1, 1, 0, 0, -1};
      dir[8] = '{0, 0, 0, 0, 0, 0, -1};
      for (int i = 0; i < NDIR; i++) plan(dir[i]);
      for (int i = 0; i < NRAND; i++) begin
         st.m     = rnd_len(3, 6, 12);
         st.da    = int'($urandom_range(0, 3));
         st.dcc   = rnd_len(3, 7, 11);
         st.ia    = int'($urandom_range(0, 3));
         st.icc   = rnd_len(3, 7, 11);
         st.early = int'($urandom_range(0, 1));
         st.roff  = int'($urandom_range(0, 4)) - 1;
         plan(st);
      end

      repeat (2) @(posedge clk);
      #1;
      chk1("rst_ack", bus.flushReqAck, 1'b0);
      chk1("rst_busy", bus.flushBusy, 1'b0);
      chk1("rst_dc", bus.dcFlushReq, 1'b0);
      chk1("rst_ic", bus.icFlushReq, 1'b0);
      chk1("rst_cmp", bus.flushComplete, 1'b0);
      chk1("rst_to", bus.flushTimeout, 1'b0);
      chkc("rst_cnt", bus.flushCount, '0);
      @(negedge clk);
      rst = 1'b0;

      exp_to  = 1'b0;
      exp_cnt = '0;
      for (int t = 0; t <= last_done + 3; t++) begin
         @(posedge clk);
         #1;
         cyc = t;
         bus.flushReq        = in_req[t];
         bus.memAccessBusy   = in_mem[t];
         bus.dcFlushReqAck   = in_dca[t];
         bus.dcFlushComplete = in_dcc[t];
         bus.icFlushReqAck   = in_ica[t];
         bus.icFlushComplete = in_icc[t];
         #1;
         if (to_clr[t]) exp_to = 1'b0;
         else if (to_set[t]) exp_to = 1'b1;
         if (c_inc[t]) exp_cnt = exp_cnt + 1'b1;
         chk1("ack", bus.flushReqAck, e_ack[t]);
         chk1("busy", bus.flushBusy, e_busy[t]);
         chk1("dc_req", bus.dcFlushReq, e_dc[t]);
         chk1("ic_req", bus.icFlushReq, e_ic[t]);
         chk1("complete", bus.flushComplete, e_cmp[t]);
         chk1("timeout", bus.flushTimeout, exp_to);
         chkc("count", bus.flushCount, exp_cnt);
      end

      // Reset mid-flush, asserted between clock edges while in DC_WAIT.
      cyc = -1;
      @(posedge clk); #1 bus.flushReq = 1'b1; #1 chk1("mr_ack", bus.flushReqAck, 1'b1);
      @(posedge clk); #1 bus.flushReq = 1'b0; #1 chk1("mr_busy", bus.flushBusy, 1'b1);
      @(posedge clk); #1 bus.dcFlushReqAck = 1'b1; #1 chk1("mr_dc", bus.dcFlushReq, 1'b1);
      @(posedge clk); #1 bus.dcFlushReqAck = 1'b0; bus.flushReq = 1'b1;
      #1 chk1("mr_wait_dc", bus.dcFlushReq, 1'b0);
      #1 rst = 1'b1;
      #1;
      chk1("ar_ack", bus.flushReqAck, 1'b0);
      chk1("ar_busy", bus.flushBusy, 1'b0);
      chk1("ar_dc", bus.dcFlushReq, 1'b0);
      chk1("ar_ic", bus.icFlushReq, 1'b0);
      chk1("ar_cmp", bus.flushComplete, 1'b0);
      chk1("ar_to", bus.flushTimeout, 1'b0);
      chkc("ar_cnt", bus.flushCount, '0);
      @(negedge clk);
      rst = 1'b0;
      #1 chk1("post_ack", bus.flushReqAck, 1'b1);
      @(posedge clk); #1 bus.flushReq = 1'b0;
      #1 chk1("post_busy", bus.flushBusy, 1'b1);
      @(posedge clk); #1 bus.dcFlushReqAck = 1'b1; bus.dcFlushComplete = 1'b1;
      #1 chk1("post_dc", bus.dcFlushReq, 1'b1);
      @(posedge clk); #1 bus.dcFlushReqAck = 1'b0; bus.dcFlushComplete = 1'b0;
      bus.icFlushReqAck = 1'b1; bus.icFlushComplete = 1'b1;
      #1 chk1("post_ic", bus.icFlushReq, 1'b1);
      @(posedge clk); #1 bus.icFlushReqAck = 1'b0; bus.icFlushComplete = 1'b0;
      #1 chk1("post_cmp", bus.flushComplete, 1'b1);
      chkc("post_cnt_done", bus.flushCount, '0);
      @(posedge clk); #2;
      chkc("post_cnt", bus.flushCount, 2'd1);
      chk1("post_idle", bus.flushBusy, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
